// File: rtl/karatsuba_seq_mult_if.sv
// Valid/ready operand and product channels of the sequential Karatsuba multiplier.
interface karatsuba_seq_mult_if #(
    parameter int WIDTH = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/karatsuba_seq_mult.sv
// Sequential unsigned Karatsuba multiplier: one shared (HALF+1)-bit multiplier is
// reused for the high, low and middle partial products, then the results are combined.
module karatsuba_seq_mult #(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    karatsuba_seq_mult_if.slave bus,
    output logic                busy,
    output logic [31:0]         op_count
);
    localparam int HALF = WIDTH / 2;
    localparam int PW   = WIDTH + 2;
    localparam int SW   = 2 * WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        MUL_HH,
        MUL_LL,
        MUL_MID,
        COMBINE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [HALF-1:0] a_h, a_l, b_h, b_l;
    logic [HALF:0]   mul_a, mul_b;
    logic [PW-1:0]   mul_q;
    logic [PW-1:0]   p_hh, p_ll, p_mid, mid;
    logic            accept;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_next    = state;
        // Ready is masked by reset so nothing can be accepted while the block is held.
        bus.in_ready  = (state == IDLE) && !rst;
        bus.out_valid = (state == DONE);
        busy          = (state != IDLE);
        accept        = bus.in_valid && bus.in_ready;
        case (state)
            IDLE:    if (accept) state_next = MUL_HH;
            MUL_HH:  state_next = MUL_LL;
            MUL_LL:  state_next = MUL_MID;
            MUL_MID: state_next = COMBINE;
            COMBINE: state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand select for the single shared multiplier; middle sums keep their carry bit.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MUL_HH: begin
                mul_a = {1'b0, a_h};
                mul_b = {1'b0, b_h};
            end
            MUL_LL: begin
                mul_a = {1'b0, a_l};
                mul_b = {1'b0, b_l};
            end
            MUL_MID: begin
                mul_a = {1'b0, a_h} + {1'b0, a_l};
                mul_b = {1'b0, b_h} + {1'b0, b_l};
            end
            default: ;
        endcase
        mul_q = PW'(mul_a) * PW'(mul_b);
        mid   = p_mid - p_hh - p_ll;
    end

    // NOTE: operand halves carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            {a_h, a_l} <= bus.in1;
            {b_h, b_l} <= bus.in2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_hh        <= '0;
            p_ll        <= '0;
            p_mid       <= '0;
            bus.product <= '0;
            op_count    <= '0;
        end else begin
            case (state)
                MUL_HH:  p_hh  <= mul_q;
                MUL_LL:  p_ll  <= mul_q;
                MUL_MID: p_mid <= mul_q;
                COMBINE: bus.product <= (2*WIDTH)'((SW'(p_hh) << WIDTH)
                                                 + (SW'(mid) << HALF)
                                                 + SW'(p_ll));
                DONE:    if (bus.out_ready) op_count <= op_count + 32'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// Randomized self-checking bench for karatsuba_seq_mult against a plain 128-bit product model.
module tb_karatsuba_seq_mult;
    localparam int WIDTH = 64;
    localparam int N_RANDOM = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [31:0] op_count;

    karatsuba_seq_mult_if #(.WIDTH(WIDTH)) bus ();

    karatsuba_seq_mult #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_count = '0;
    int unsigned last_acc = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] golden(input logic [63:0] a, input logic [63:0] b);
        return {64'd0, a} * {64'd0, b};
    endfunction

    // Runs one full transaction starting at a negedge; ends at a negedge back in IDLE.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input int stall,
                         input bit gap_chk, input bit poke);
        logic [127:0] exp;
        int           waited;
        int           lat;
        int unsigned  acc;
        exp           = golden(a, b);
        bus.in1       = a;
        bus.in2       = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 128'(0), 128'(1));
            bus.in_valid = 1'b0;
            return;
        end
        acc = cycle + 1;
        if (gap_chk) check("accept_gap", 128'((acc - last_acc) >= 6), 128'(1));
        last_acc = acc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in1      = {$urandom, $urandom};
        bus.in2      = {$urandom, $urandom};
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 128'(lat), 128'(4));
        if (!bus.out_valid) return;
        check("product", bus.product, exp);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.in1      = 64'h1234_5678_9ABC_DEF0;
                bus.in2      = 64'h0FED_CBA9_8765_4321;
            end
            @(negedge clk);
            check("bp_valid",   128'(bus.out_valid), 128'(1));
            check("bp_product", bus.product, exp);
            check("bp_ready",   128'(bus.in_ready), 128'(0));
            check("bp_busy",    128'(busy), 128'(1));
            check("bp_count",   128'(op_count), 128'(exp_count));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        check("count",      128'(op_count), 128'(exp_count));
        check("idle_ready", 128'(bus.in_ready), 128'(1));
        check("idle_valid", 128'(bus.out_valid), 128'(0));
        check("idle_busy",  128'(busy), 128'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra, rb;
        int          st;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready",   128'(bus.in_ready), 128'(1));
        check("post_rst_valid",   128'(bus.out_valid), 128'(0));
        check("post_rst_product", bus.product, 128'(0));
        check("post_rst_count",   128'(op_count), 128'(0));
        check("post_rst_busy",    128'(busy), 128'(0));
        @(negedge clk);

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1'b0);
        check("max_const", bus.product, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        do_op(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 0, 1'b0, 1'b0);
        check("cross_const", bus.product, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
        do_op(64'd0, 64'hDEAD_BEEF_CAFE_BABE, 0, 1'b0, 1'b0);
        check("zero_const", bus.product, 128'd0);
        do_op(64'hA5A5_0000_FFFF_1234, 64'h8000_0001_7FFF_FFFF, 10, 1'b0, 1'b1);

        // Abandon an operation while the middle product is being formed.
        bus.in1       = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.in2       = 64'h5555_5555_5555_5555;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_count = '0;
        check("midrst_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_busy",  128'(busy), 128'(0));
        check("midrst_ready", 128'(bus.in_ready), 128'(0));
        check("midrst_count", 128'(op_count), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_ghost_valid", 128'(bus.out_valid), 128'(0));
        end
        do_op(64'd3, 64'd5, 0, 1'b0, 1'b0);
        check("three_by_five", bus.product, 128'd15);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = '0;
        @(negedge clk);
        for (int n = 0; n < N_RANDOM; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 15))
                0: ra = '1;
                1: rb = '1;
                2: ra = '0;
                3: rb = {32'd0, $urandom};
                default: ;
            endcase
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op(ra, rb, st, n != 0, 1'b0);
        end
        check("final_count", 128'(op_count), 128'(N_RANDOM));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
